// File: rtl/alu_cmd_responder_pkg.sv
// Shared definitions for the ALU command responder: opcodes, FSM state
// encodings and a small opcode helper.
package alu_cmd_responder_pkg;

  // Opcodes carried on cmd_op
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // Top-level FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // True for the only multi-cycle opcode
  function automatic logic is_mul(input logic [2:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier. The first partial product is
// folded into the load cycle so the full product is ready WIDTH-1 edges
// after start; done pulses for one cycle once the product is complete.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] STEPS_LEFT = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] STEP_ONE   = SHW'(1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [SHW-1:0]     step_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [2*WIDTH-1:0] first_pp_next;
  logic [2*WIDTH-1:0] partial_next;

  // Partial products: bit 0 of b at load time, then the shifted multiplier
  always_comb begin
    first_pp_next = b[0] ? {{WIDTH{1'b0}}, a} : '0;
    partial_next  = mplier_reg[0] ? mcand_reg : '0;
  end

  // Load on start, then accumulate one multiplier bit per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      step_reg   <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (start) begin
      acc_reg    <= first_pp_next;
      mcand_reg  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_reg <= {1'b0, b[WIDTH-1:1]};
      step_reg   <= STEPS_LEFT;
      busy_reg   <= 1'b1;
      done_reg   <= 1'b0;
    end else if (busy_reg) begin
      acc_reg    <= acc_reg + partial_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      step_reg   <= step_reg - STEP_ONE;
      if (step_reg == STEP_ONE) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end else begin
        done_reg <= 1'b0;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/alu_cmd_responder.sv
// Sequential ALU execution unit: accepts one command over a valid/ready
// channel, executes it (one cycle, or WIDTH cycles for MUL) and holds a
// registered result plus flags on the response channel until taken.
module alu_cmd_responder
  import alu_cmd_responder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_carry,
  output logic                 rsp_ovf
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_MUL = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  logic [1:0]         state_reg;
  logic [SHW-1:0]     cnt_reg;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               zero_reg;
  logic               carry_reg;
  logic               ovf_reg;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [SHW-1:0]     sh_amt;
  logic [2*WIDTH-1:0] alu_result_next;
  logic               alu_carry_next;
  logic               alu_ovf_next;
  logic [2*WIDTH-1:0] fin_result_next;
  logic               fin_carry_next;
  logic               fin_ovf_next;
  logic               exec_last_next;

  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  // The multiplier loads straight from the command bus on the accept edge
  assign mul_start = (state_reg == S_IDLE) && cmd_valid && is_mul(cmd_op);

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (cmd_a),
    .b       (cmd_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath from the latched operands
  always_comb begin
    sum_ext         = {1'b0, a_reg} + {1'b0, b_reg};
    diff_ext        = {1'b0, a_reg} - {1'b0, b_reg};
    sh_amt          = b_reg[SHW-1:0];
    alu_result_next = '0;
    alu_carry_next  = 1'b0;
    alu_ovf_next    = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_result_next = {{WIDTH{1'b0}}, sum_ext[WIDTH-1:0]};
        alu_carry_next  = sum_ext[WIDTH];
        alu_ovf_next    = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result_next = {{WIDTH{1'b0}}, diff_ext[WIDTH-1:0]};
        alu_carry_next  = diff_ext[WIDTH];
        alu_ovf_next    = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND: alu_result_next = {{WIDTH{1'b0}}, a_reg & b_reg};
      OP_OR:  alu_result_next = {{WIDTH{1'b0}}, a_reg | b_reg};
      OP_XOR: alu_result_next = {{WIDTH{1'b0}}, a_reg ^ b_reg};
      OP_SHL: alu_result_next = {{WIDTH{1'b0}}, a_reg << sh_amt};
      OP_SHR: alu_result_next = {{WIDTH{1'b0}}, a_reg >> sh_amt};
      default: alu_result_next = '0;
    endcase
  end

  // Select the multiplier or single-cycle result and decide when EXEC ends
  always_comb begin
    fin_result_next = alu_result_next;
    fin_carry_next  = alu_carry_next;
    fin_ovf_next    = alu_ovf_next;
    exec_last_next  = 1'b1;
    if (is_mul(op_reg)) begin
      fin_result_next = mul_product;
      fin_carry_next  = |mul_product[2*WIDTH-1:WIDTH];
      fin_ovf_next    = 1'b0;
      exec_last_next  = (cnt_reg == '0) && mul_done && !mul_busy;
    end
  end

  // Handshake FSM; response registers only change on EXEC->DONE or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            op_reg    <= cmd_op;
            a_reg     <= cmd_a;
            b_reg     <= cmd_b;
            cnt_reg   <= is_mul(cmd_op) ? CNT_MUL : '0;
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_last_next) begin
            result_reg <= fin_result_next;
            zero_reg   <= ~|fin_result_next;
            carry_reg  <= fin_carry_next;
            ovf_reg    <= fin_ovf_next;
            state_reg  <= S_DONE;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_reg == S_IDLE);
  assign rsp_valid  = (state_reg == S_DONE);
  assign rsp_result = result_reg;
  assign rsp_zero   = zero_reg;
  assign rsp_carry  = carry_reg;
  assign rsp_ovf    = ovf_reg;

endmodule
